// File: rtl/conv_row_param.sv
// conv_row_param: 1-D FIR filter applied along each image row.
// Keeps the last N accepted pixels of the current row and emits one filtered
// pixel for every column c >= N-1. The output is |S| or max(S,0), saturated
// to DW bits, and appears exactly two cycles after the accepting edge.
// Coefficients are written into a shadow set at any time. The shadow set is
// copied to the active set on the first pixel of each frame.

module conv_row_param #(
    parameter int W  = 220,
    parameter int H  = 220,
    parameter int N  = 7,
    parameter int DW = 8,
    parameter int KW = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DW-1:0]        pxl_in,
    input  logic                 in_valid,
    input  logic                 coef_we,
    input  logic [3:0]           coef_idx,
    input  logic signed [KW-1:0] coef_data,
    input  logic                 abs_mode,
    output logic [DW-1:0]        pxl_out,
    output logic                 out_valid,
    output logic                 frame_done,
    output logic [11:0]          col_idx
);

    localparam int SW = DW + KW + 4;     // full-precision signed sum width
    localparam int CW = 12;              // column / row counter width
    localparam int FW = 4;               // window fill counter width

    localparam logic [CW-1:0] LAST_COL  = CW'(W - 1);
    localparam logic [CW-1:0] LAST_ROW  = CW'(H - 1);
    localparam logic [FW-1:0] FILL_FULL = FW'(N);
    localparam logic [FW-1:0] FILL_EMIT = FW'(N - 1);

    // Coefficient value loaded at reset: -1, 0, +1, 0 repeating by tap index.
    function automatic logic signed [KW-1:0] coef_reset_val(input int k);
        logic signed [KW-1:0] v;
        case (k % 4)
            0:       v = {KW{1'b1}};
            2:       v = {{(KW-1){1'b0}}, 1'b1};
            default: v = '0;
        endcase
        return v;
    endfunction

    // One tap product: the pixel is unsigned and the coefficient is signed.
    // Both are extended to the full sum width, so the product cannot overflow.
    function automatic logic signed [SW-1:0] tap_product(
        input logic [DW-1:0]        p,
        input logic signed [KW-1:0] c
    );
        logic signed [SW-1:0] pe;
        logic signed [SW-1:0] ce;
        pe = $signed(SW'(p));
        ce = SW'(c);
        return pe * ce;
    endfunction

    // Counters and window
    logic [CW-1:0]        col_r;
    logic [CW-1:0]        row_r;
    logic [FW-1:0]        fill_r;
    logic [DW-1:0]        win_r    [N];
    logic signed [KW-1:0] shadow_r [N];
    logic signed [KW-1:0] coef_r   [N];

    // Pipeline stage 1: the window holds the accepted pixel.
    logic                 v1_r;
    logic                 abs1_r;
    logic                 last1_r;

    // Pipeline stage 2: the sum is registered.
    logic signed [SW-1:0] sum2_r;
    logic                 v2_r;
    logic                 abs2_r;
    logic                 last2_r;

    // Output registers
    logic [DW-1:0]        pxl_out_r;
    logic                 out_valid_r;
    logic                 frame_done_r;

    // Combinational helpers
    logic                 col_last_s;
    logic                 row_last_s;
    logic                 first_px_s;
    logic                 emit_s;
    logic signed [SW-1:0] sum_s;
    logic signed [SW-1:0] mag_s;
    logic [DW-1:0]        pxl_s;

    // Decode the position of the pixel that is offered this cycle.
    always_comb begin
        col_last_s = (col_r == LAST_COL);
        row_last_s = (row_r == LAST_ROW);
        first_px_s = in_valid && (row_r == '0) && (col_r == '0);
        emit_s     = (fill_r >= FILL_EMIT);
    end

    // Column and row counters advance only on accepted pixels.
    always_ff @(posedge clk) begin
        if (reset) begin
            col_r <= '0;
            row_r <= '0;
        end else if (in_valid) begin
            if (col_last_s) begin
                col_r <= '0;
                if (row_last_s) begin
                    row_r <= '0;
                end else begin
                    row_r <= row_r + CW'(1);
                end
            end else begin
                col_r <= col_r + CW'(1);
            end
        end
    end

    // Window occupancy clears at each column wrap, so a window never spans rows.
    always_ff @(posedge clk) begin
        if (reset) begin
            fill_r <= '0;
        end else if (in_valid) begin
            if (col_last_s) begin
                fill_r <= '0;
            end else if (fill_r < FILL_FULL) begin
                fill_r <= fill_r + FW'(1);
            end
        end
    end

    // Pixel window shift register; index N-1 holds the newest pixel.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < N; k++) begin
                win_r[k] <= '0;
            end
        end else if (in_valid) begin
            for (int k = 0; k < N - 1; k++) begin
                win_r[k] <= win_r[k+1];
            end
            win_r[N-1] <= pxl_in;
        end
    end

    // Shadow write port and the frame-start copy into the active set.
    // The copy reads the pre-edge shadow, so a coincident write waits a frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < N; k++) begin
                shadow_r[k] <= coef_reset_val(k);
                coef_r[k]   <= coef_reset_val(k);
            end
        end else begin
            if (first_px_s) begin
                for (int k = 0; k < N; k++) begin
                    coef_r[k] <= shadow_r[k];
                end
            end
            for (int k = 0; k < N; k++) begin
                if (coef_we && (coef_idx == 4'(k))) begin
                    shadow_r[k] <= coef_data;
                end
            end
        end
    end

    // Stage 1 qualifiers: output wanted, post-processing mode, end of frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            v1_r    <= 1'b0;
            abs1_r  <= 1'b0;
            last1_r <= 1'b0;
        end else begin
            v1_r    <= in_valid && emit_s;
            abs1_r  <= abs_mode;
            last1_r <= in_valid && col_last_s && row_last_s;
        end
    end

    // Dot product of the window with the active coefficients; coef[0] is oldest.
    always_comb begin
        sum_s = '0;
        for (int k = 0; k < N; k++) begin
            sum_s = sum_s + tap_product(win_r[k], coef_r[k]);
        end
    end

    // Stage 2 registers the full-precision sum.
    always_ff @(posedge clk) begin
        if (reset) begin
            sum2_r  <= '0;
            v2_r    <= 1'b0;
            abs2_r  <= 1'b0;
            last2_r <= 1'b0;
        end else begin
            sum2_r  <= sum_s;
            v2_r    <= v1_r;
            abs2_r  <= abs1_r;
            last2_r <= last1_r;
        end
    end

    // Post-processing: absolute value or clamp at zero, then saturate to DW bits.
    always_comb begin
        mag_s = '0;
        pxl_s = '0;
        if (sum2_r < 0) begin
            if (abs2_r) begin
                mag_s = -sum2_r;
            end else begin
                mag_s = '0;
            end
        end else begin
            mag_s = sum2_r;
        end
        if (|mag_s[SW-1:DW]) begin
            pxl_s = '1;
        end else begin
            pxl_s = mag_s[DW-1:0];
        end
    end

    // Output registers; pxl_out holds its last value when no output is produced.
    always_ff @(posedge clk) begin
        if (reset) begin
            pxl_out_r    <= '0;
            out_valid_r  <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            out_valid_r  <= v2_r;
            frame_done_r <= v2_r && last2_r;
            if (v2_r) begin
                pxl_out_r <= pxl_s;
            end
        end
    end

    assign pxl_out    = pxl_out_r;
    assign out_valid  = out_valid_r;
    assign frame_done = frame_done_r;
    assign col_idx    = col_r;

endmodule

// File: tb/tb_conv_row_param.sv
// Scoreboard testbench for conv_row_param (W=16, H=2, N=7).
// The driver updates a row-buffer reference model and queues each expected
// output with the cycle in which it must appear. The monitor pops entries and
// compares them whenever out_valid is high.

module tb_conv_row_param;

    localparam int W  = 16;
    localparam int H  = 2;
    localparam int N  = 7;
    localparam int DW = 8;
    localparam int KW = 4;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [DW-1:0]        pxl_in;
    logic                 in_valid;
    logic                 coef_we;
    logic [3:0]           coef_idx;
    logic signed [KW-1:0] coef_data;
    logic                 abs_mode;
    logic [DW-1:0]        pxl_out;
    logic                 out_valid;
    logic                 frame_done;
    logic [11:0]          col_idx;

    conv_row_param #(.W(W), .H(H), .N(N), .DW(DW), .KW(KW)) dut (
        .clk        (clk),
        .reset      (reset),
        .pxl_in     (pxl_in),
        .in_valid   (in_valid),
        .coef_we    (coef_we),
        .coef_idx   (coef_idx),
        .coef_data  (coef_data),
        .abs_mode   (abs_mode),
        .pxl_out    (pxl_out),
        .out_valid  (out_valid),
        .frame_done (frame_done),
        .col_idx    (col_idx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int val;
        int fd;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   started  = 1'b0;
    int   last_pxl = 0;

    // Reference model state
    int m_col;
    int m_row;
    int m_shd[N];
    int m_act[N];
    int m_rowbuf[W];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    function automatic int init_coef(input int k);
        case (k % 4)
            0:       return -1;
            2:       return 1;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_col = 0;
        m_row = 0;
        for (int k = 0; k < N; k++) begin
            m_shd[k] = init_coef(k);
            m_act[k] = init_coef(k);
        end
        q.delete();
    endtask

    // Model one offered cycle; the accepting edge is the next posedge.
    task automatic model_step(input int v, input int p, input int a,
                              input int we, input int idx, input int d);
        exp_t e;
        int s;
        int r;
        if (v != 0) begin
            if (m_row == 0 && m_col == 0) begin
                for (int k = 0; k < N; k++) m_act[k] = m_shd[k];
            end
            m_rowbuf[m_col] = p;
            if (m_col >= N - 1) begin
                s = 0;
                for (int k = 0; k < N; k++) s += m_act[k] * m_rowbuf[m_col - N + 1 + k];
                if (a != 0) r = (s < 0) ? -s : s;
                else        r = (s < 0) ? 0 : s;
                if (r > 255) r = 255;
                e.val = r;
                e.fd  = (m_col == W - 1 && m_row == H - 1) ? 1 : 0;
                e.cyc = cyc + 3;
                q.push_back(e);
            end
            if (m_col == W - 1) begin
                m_col = 0;
                m_row = (m_row == H - 1) ? 0 : m_row + 1;
            end else begin
                m_col++;
            end
        end
        if (we != 0 && idx < N) m_shd[idx] = d;
    endtask

    task automatic cyc_drive(input int v, input int p, input int a,
                             input int we, input int idx, input int d);
        @(negedge clk);
        #1;
        in_valid  = (v != 0);
        pxl_in    = DW'(p);
        abs_mode  = (a != 0);
        coef_we   = (we != 0);
        coef_idx  = 4'(idx);
        coef_data = KW'(d);
        model_step(v, p, a, we, idx, d);
    endtask

    task automatic idle();
        cyc_drive(0, $urandom_range(0, 255), $urandom_range(0, 1), 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        reset    = 1'b1;
        in_valid = 1'b0;
        coef_we  = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        reset = 1'b0;
    endtask

    // mode: 0 p=c, 1 p=100-c, 2 p=255, 3 random.
    // abs_sel: 0/1 fixed, 2 random per pixel, 3 row0=abs and row1=clamp.
    // stall: 0 none, 1 two idle cycles after each pixel, 2 random 0..2 idles.
    task automatic drive_frame(input int mode, input int stall, input int abs_sel,
                               input int wr_col, input int rst_row, input int rst_col);
        int p;
        int a;
        int we;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r == rst_row && c == rst_col) begin
                    do_reset();
                    return;
                end
                case (mode)
                    0:       p = c;
                    1:       p = 100 - c;
                    2:       p = 255;
                    default: p = $urandom_range(0, 255);
                endcase
                if (abs_sel == 2)      a = $urandom_range(0, 1);
                else if (abs_sel == 3) a = (r == 0) ? 1 : 0;
                else                   a = abs_sel;
                we = ((r == 0 && c == wr_col) || (mode == 3 && $urandom_range(0, 7) == 0)) ? 1 : 0;
                cyc_drive(1, p, a, we, $urandom_range(0, 15), int'($urandom_range(0, 15)) - 8);
                if (stall == 1) begin
                    repeat (2) idle();
                end else if (stall == 2) begin
                    repeat ($urandom_range(0, 2)) idle();
                end
            end
        end
    endtask

    // Monitor: reset state, column debug output, and the output scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (started) begin
            if (reset) begin
                chk("reset_out_valid", int'(out_valid), 0);
                chk("reset_pxl_out", int'(pxl_out), 0);
                chk("reset_frame_done", int'(frame_done), 0);
                chk("reset_col_idx", int'(col_idx), 0);
                last_pxl = 0;
            end else begin
                chk("col_idx", int'(col_idx), m_col);
                if (frame_done && !out_valid) chk("frame_done_without_valid", int'(frame_done), 0);
                if (out_valid) begin
                    if (q.size() == 0) begin
                        chk("spurious_out_valid", int'(out_valid), 0);
                    end else begin
                        e = q.pop_front();
                        chk("pxl_out", int'(pxl_out), e.val);
                        chk("frame_done", int'(frame_done), e.fd);
                        chk("latency_cycle", cyc, e.cyc);
                    end
                    last_pxl = int'(pxl_out);
                end else begin
                    chk("pxl_out_hold", int'(pxl_out), last_pxl);
                end
            end
        end
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        pxl_in    = '0;
        coef_we   = 1'b0;
        coef_idx  = '0;
        coef_data = '0;
        abs_mode  = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        started = 1'b1;
        @(negedge clk);
        #1;
        reset = 1'b0;

        // Ascending rows with default coefficients give 4 everywhere.
        drive_frame(0, 0, 1, -1, -1, -1);
        // Descending rows: row 0 uses absolute value, row 1 clamps.
        drive_frame(1, 0, 3, -1, -1, -1);
        repeat (3) idle();

        // All taps set to +7, plus one ignored out-of-range index.
        for (int k = 0; k < N; k++) cyc_drive(0, 0, 0, 1, k, 7);
        cyc_drive(0, 0, 0, 1, 12, -8);
        // Saturating frame with a shadow write coincident with the first pixel.
        drive_frame(2, 0, 1, 0, -1, -1);
        // Random frame shows whether the coincident write landed next frame.
        drive_frame(3, 0, 2, -1, -1, -1);

        // Stalled frame with default coefficients (1,0,0,1 valid pattern).
        do_reset();
        drive_frame(0, 1, 1, -1, -1, -1);

        // Random pixels, random stalls, random coefficient writes.
        repeat (3) drive_frame(3, 2, 2, -1, -1, -1);

        // Reset at row 1, col 9, then a fresh frame.
        drive_frame(0, 0, 1, -1, 1, 9);
        drive_frame(0, 0, 1, -1, -1, -1);
        drive_frame(3, 2, 2, -1, -1, -1);

        // Drain outstanding expectations within a bounded number of cycles.
        for (int i = 0; i < 20 && q.size() > 0; i++) idle();
        repeat (3) idle();
        chk("scoreboard_drained", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
